// File: rtl/sqrt3_arb_pkg.sv
// sqrt3_arb_pkg: shared definitions for the sqrt3 core arbiter.
//   state_t      - arbiter FSM state encoding (2 bits)
//   DEF_DATA_W   - default operand/result width
//   DEF_START_TO - default start-watchdog limit in cycles
package sqrt3_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_START_TO = 8;

endpackage

// File: rtl/sqrt3_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   elig  in  N_REQ  - eligible requester mask
//   last  in  IDX_W  - index served most recently; search starts at last+1
//   pick  out N_REQ  - one-hot winner (zero when nothing is eligible)
//   idx   out IDX_W  - binary index of the winner
//   found out 1      - at least one requester was eligible
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] pick,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      logic [IDX_W-1:0] j;
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      // Walk last+1 .. last+N_REQ modulo N_REQ; the first hit wins, so the
      // requester just served is considered last.
      for (int k = 1; k <= N_REQ; k++) begin
         j = IDX_W'((int'(last) + k) % N_REQ);
         if (!found && elig[j]) begin
            found   = 1'b1;
            pick[j] = 1'b1;
            idx     = j;
         end
      end
   end

endmodule

// File: rtl/sqrt3_arbiter.sv
// sqrt3_arbiter: round-robin arbiter sharing one sqrt3 cube-root core.
//   clk, rst          - clock, asynchronous active-high reset
//   req, req_data     - level requests and packed operands (slice i per requester)
//   grant             - one-hot requester currently in service
//   done, err         - one-cycle completion pulse / watchdog-abort flag
//   result            - last result, held until the next done
//   busy              - arbiter not idle
//   core_start/x/rst  - drive the core; core_rst also pulses on watchdog abort
//   core_busy/result  - returned by the core
module sqrt3_arbiter
   import sqrt3_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int START_TO = DEF_START_TO
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       result,
   output logic                    err,
   output logic                    busy,
   output logic                    core_start,
   output logic [DATA_W-1:0]       core_x,
   output logic                    core_rst,
   input  logic                    core_busy,
   input  logic [DATA_W-1:0]       core_result
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = 8;

   state_t                         state, state_nxt;
   logic [N_REQ-1:0]               grant_nxt, done_nxt, lock, lock_nxt;
   logic [IDX_W-1:0]               last, last_nxt;
   logic [CNT_W-1:0]               cnt, cnt_nxt;
   logic [DATA_W-1:0]              result_nxt, core_x_nxt;
   logic                           err_nxt, core_start_nxt, abort, abort_nxt;

   logic [N_REQ-1:0][DATA_W-1:0]   ops;
   logic [N_REQ-1:0]               pick;
   logic [IDX_W-1:0]               pick_idx;
   logic                           pick_found;

   assign ops = req_data;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .elig  (req & ~lock),
      .last  (last),
      .pick  (pick),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         grant      <= '0;
         done       <= '0;
         err        <= 1'b0;
         result     <= '0;
         core_x     <= '0;
         core_start <= 1'b0;
         lock       <= '0;
         last       <= IDX_W'(N_REQ - 1);
         cnt        <= '0;
         abort      <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         result     <= result_nxt;
         core_x     <= core_x_nxt;
         core_start <= core_start_nxt;
         lock       <= lock_nxt;
         last       <= last_nxt;
         cnt        <= cnt_nxt;
         abort      <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      done_nxt       = '0;
      err_nxt        = 1'b0;
      result_nxt     = result;
      core_x_nxt     = core_x;
      core_start_nxt = core_start;
      last_nxt       = last;
      cnt_nxt        = cnt;
      abort_nxt      = 1'b0;
      // done is high exactly in DONE, so OR-ing it in latches the lock at the
      // end of service; a low req always wins and re-arms the requester.
      lock_nxt       = (lock | done) & req;

      unique case (state)
         S_IDLE: begin
            if (pick_found) begin
               grant_nxt      = pick;
               last_nxt       = pick_idx;
               core_x_nxt     = ops[pick_idx];
               core_start_nxt = 1'b1;
               cnt_nxt        = '0;
               state_nxt      = S_START;
            end
         end
         S_START: begin
            if (core_busy) begin
               core_start_nxt = 1'b0;
               state_nxt      = S_RUN;
            end else if (cnt == CNT_W'(START_TO - 1)) begin
               // Core never acknowledged: reset it and finish with an error.
               core_start_nxt = 1'b0;
               abort_nxt      = 1'b1;
               result_nxt     = '0;
               done_nxt       = grant;
               err_nxt        = 1'b1;
               state_nxt      = S_DONE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (!core_busy) begin
               result_nxt = core_result;
               done_nxt   = grant;
               state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            grant_nxt = '0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy     = (state != S_IDLE);
   assign core_rst = rst | abort;

endmodule

// File: tb/tb_sqrt3_arbiter.sv
// tb_sqrt3_arbiter: directed bench for sqrt3_arbiter with a behavioural cube-root
// core. Expected completions are queued by the stimulus and compared by a
// monitor whenever done pulses.
module tb_sqrt3_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   grant, done;
   logic [W-1:0]   result, core_x, core_result;
   logic           err, busy, core_start, core_rst, core_busy;
   logic           hang;
   int             mcnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int           idx;
      logic [W-1:0] res;
      logic         e;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   sqrt3_arbiter #(.N_REQ(N), .DATA_W(W), .START_TO(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
      .core_start(core_start), .core_x(core_x), .core_rst(core_rst),
      .core_busy(core_busy), .core_result(core_result)
   );

   always #5 clk = ~clk;

   // Behavioural core: busy rises one cycle after start, stays LAT cycles.
   // With hang set it ignores start, which exercises the watchdog.
   function automatic logic [W-1:0] cbrt(input logic [W-1:0] x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= int'(x)) r++;
      return W'(r);
   endfunction

   always @(posedge clk or posedge core_rst) begin
      if (core_rst) begin
         core_busy   <= 1'b0;
         mcnt        <= 0;
         core_result <= '0;
      end else if (core_busy) begin
         if (mcnt <= 1) core_busy <= 1'b0;
         mcnt <= mcnt - 1;
      end else if (core_start && !hang) begin
         core_busy   <= 1'b1;
         mcnt        <= LAT;
         core_result <= cbrt(core_x);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_exp(input int idx, input logic [W-1:0] res, input logic e);
      exp_t x;
      x.idx = idx;
      x.res = res;
      x.e   = e;
      exp_q.push_back(x);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && done !== '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=%b expected no pulse", done);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_onehot", 32'(done), 32'(4'b0001 << mon_e.idx));
            chk("done_result", 32'(result), 32'(mon_e.res));
            chk("done_err", 32'(err), 32'(mon_e.e));
         end
      end
   end

   task automatic wait_done(output int who);
      who = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done !== '0) begin
            for (int b = 0; b < N; b++) if (done[b]) who = b;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL wait_done: got no done within 60 cycles expected a pulse");
   endtask

   task automatic wait_busy();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (core_busy) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_busy: got no core_busy within 20 cycles expected busy");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected bench end");
      $fatal(1, "timeout");
   end

   initial begin
      int who, m;
      rst = 1'b1; req = '0; req_data = '0; hang = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_core_start", 32'(core_start), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_core_x", 32'(core_x), 0);
      chk("rst_core_rst", 32'(core_rst), 1);
      @(posedge clk); #1 rst = 1'b0;

      // Single request: cbrt(27) = 3
      req_data[7:0] = 8'd27; req = 4'b0001;
      push_exp(0, 8'd3, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("single_grant", 32'(grant), 32'h1);
      chk("single_core_start", 32'(core_start), 1);
      chk("single_core_x", 32'(core_x), 27);
      chk("single_busy", 32'(busy), 1);
      wait_done(who);
      chk("single_who", 32'(who), 0);
      @(posedge clk); #1 req = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      // Contention: operands 1, 8, 64, 125 -> 1, 2, 4, 5; order 0,1,2,3,0
      req_data = {8'd125, 8'd64, 8'd8, 8'd1};
      push_exp(0, 8'd1, 1'b0); push_exp(1, 8'd2, 1'b0);
      push_exp(2, 8'd4, 1'b0); push_exp(3, 8'd5, 1'b0);
      push_exp(0, 8'd1, 1'b0);
      req = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         wait_done(who);
         chk("rr_order", 32'(who), 32'(s % 4));
         if (who >= 0) begin
            @(posedge clk); #1;
            if (s == 4) req = '0;
            else begin
               req[who[1:0]] = 1'b0;
               @(posedge clk); #1 req[who[1:0]] = 1'b1;
            end
         end
      end
      repeat (3) @(posedge clk); #1;

      // Lock: req[2] held high is served once only
      req_data[23:16] = 8'd8; req = 4'b0100;
      push_exp(2, 8'd2, 1'b0);
      wait_done(who);
      chk("lock_first_who", 32'(who), 2);
      repeat (15) @(negedge clk);
      chk("lock_hold_busy", 32'(busy), 0);
      chk("lock_hold_grant", 32'(grant), 0);
      @(posedge clk); #1 req = '0;
      @(posedge clk); #1 req = 4'b0100;
      push_exp(2, 8'd2, 1'b0);
      wait_done(who);
      chk("lock_again_who", 32'(who), 2);
      @(posedge clk); #1 req = '0;

      // Watchdog: core ignores start, abort 8 cycles after entering START
      @(posedge clk); #1 hang = 1'b1;
      req_data[15:8] = 8'd27; req = 4'b0010;
      push_exp(1, 8'd0, 1'b1);
      @(posedge clk);
      m = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (core_rst) begin m = i; break; end
      end
      chk("wd_core_rst_delay", 32'(m), 8);
      @(negedge clk);
      chk("wd_core_rst_width", 32'(core_rst), 0);
      @(posedge clk); #1 hang = 1'b0; req = '0;
      @(posedge clk); #1 req_data[15:8] = 8'd64; req = 4'b0010;
      push_exp(1, 8'd4, 1'b0);
      wait_done(who);
      chk("wd_after_who", 32'(who), 1);
      @(posedge clk); #1 req = '0;

      // Reset mid-RUN
      @(posedge clk); #1 req_data[7:0] = 8'd125; req = 4'b0001;
      wait_busy();
      @(negedge clk);
      chk("midrst_pre_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_grant", 32'(grant), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_core_start", 32'(core_start), 0);
      chk("midrst_core_rst", 32'(core_rst), 1);
      req = '0;
      repeat (3) @(negedge clk);
      chk("midrst_core_rst_held", 32'(core_rst), 1);
      chk("midrst_no_done", 32'(done), 0);
      @(posedge clk); #1 rst = 1'b0;
      req_data[15:0] = {8'd8, 8'd1}; req = 4'b0011;
      push_exp(0, 8'd1, 1'b0); push_exp(1, 8'd2, 1'b0);
      wait_done(who);
      chk("midrst_prio_who", 32'(who), 0);
      @(posedge clk); #1 req = 4'b0010;
      wait_done(who);
      chk("midrst_second_who", 32'(who), 1);
      @(posedge clk); #1 req = '0;

      // Request dropped during RUN still completes
      @(posedge clk); #1 req_data[15:8] = 8'd64; req = 4'b0010;
      push_exp(1, 8'd4, 1'b0);
      wait_busy();
      @(negedge clk);
      req = '0;
      wait_done(who);
      chk("drop_who", 32'(who), 1);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
